// File: rtl/stochastic_round_pipe.sv
// Multi-lane two-stage rounding unit: narrows wide accumulator words to IL.FL operands
// using truncate, round-to-nearest-even or LFSR-driven stochastic rounding, then saturates.
module stochastic_round_pipe #(
    parameter int unsigned IL    = 8,
    parameter int unsigned FL    = 12,
    parameter int unsigned GB    = 4,
    parameter int unsigned LANES = 4,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_valid,
    output logic                            i_ready,
    input  logic [LANES*(GB+2*(IL+FL))-1:0] i_data,
    input  logic [1:0]                      i_mode,
    output logic                            o_valid,
    input  logic                            o_ready,
    output logic [LANES*(IL+FL)-1:0]        o_data,
    output logic [LANES-1:0]                o_sat,
    input  logic                            i_seed_load,
    input  logic [15:0]                     i_seed,
    input  logic                            i_cnt_clr,
    output logic [15:0]                     o_sat_cnt
);
    localparam int unsigned IW = GB + 2*(IL+FL);
    localparam int unsigned OW = IL + FL;
    localparam int unsigned FW = IW - FL;
    localparam int unsigned VW = FW + 1;
    localparam logic [VW-1:0] V_MAX = {{(VW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic [VW-1:0] V_MIN = {{(VW-OW+1){1'b1}}, {(OW-1){1'b0}}};
    localparam logic [FL-1:0] HALF  = {1'b1, {(FL-1){1'b0}}};

    // Per-lane seed derivation; an all-zero state would lock the LFSR up.
    function automatic logic [15:0] lane_seed(input logic [15:0] base, input int unsigned k);
        logic [15:0] s;
        s = base ^ 16'(k * 32'h1D87);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    logic                     w_en;
    logic                     w_accept;
    logic [LANES-1:0][15:0]   r_lfsr;
    logic [LANES-1:0][FW-1:0] w_fl;
    logic [LANES-1:0][FL-1:0] w_d;
    logic [LANES-1:0]         w_up;
    logic [LANES-1:0][VW-1:0] w_v;
    logic [LANES-1:0][VW-1:0] r_s1_v;
    logic                     r_s1_valid;
    logic [LANES*OW-1:0]      w_o_data;
    logic [LANES-1:0]         w_sat;

    assign w_en     = !o_valid || o_ready;
    assign w_accept = i_valid && w_en;
    assign i_ready  = w_en;

    // Each LFSR steps once per accepted vector so results are independent of stalls.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (reset) begin
                r_lfsr[k] <= lane_seed(SEED, k);
            end else if (i_seed_load) begin
                r_lfsr[k] <= lane_seed(i_seed, k);
            end else if (w_accept) begin
                r_lfsr[k] <= lfsr_next(r_lfsr[k]);
            end
        end
    end

    // Stage-1 rounding: floor plus a mode-dependent round-up bit, one bit wider than floor.
    always_comb begin
        w_fl = '0;
        w_d  = '0;
        w_up = '0;
        w_v  = '0;
        for (int k = 0; k < LANES; k++) begin
            w_fl[k] = i_data[k*IW+FL +: FW];
            w_d[k]  = i_data[k*IW +: FL];
            case (i_mode)
                2'b00:   w_up[k] = 1'b0;
                2'b10:   w_up[k] = (r_lfsr[k][FL-1:0] < w_d[k]);
                default: w_up[k] = (w_d[k] > HALF) || ((w_d[k] == HALF) && w_fl[k][0]);
            endcase
            w_v[k] = {w_fl[k][FW-1], w_fl[k]} + VW'(w_up[k]);
        end
    end

    // Stage-2 clamp to the signed OW-bit range.
    always_comb begin
        w_o_data = '0;
        w_sat    = '0;
        for (int k = 0; k < LANES; k++) begin
            if ($signed(r_s1_v[k]) > $signed(V_MAX)) begin
                w_sat[k]              = 1'b1;
                w_o_data[k*OW +: OW]  = V_MAX[OW-1:0];
            end else if ($signed(r_s1_v[k]) < $signed(V_MIN)) begin
                w_sat[k]              = 1'b1;
                w_o_data[k*OW +: OW]  = V_MIN[OW-1:0];
            end else begin
                w_o_data[k*OW +: OW]  = r_s1_v[k][OW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_v     <= '0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_sat      <= '0;
        end else if (w_en) begin
            r_s1_valid <= i_valid;
            o_valid    <= r_s1_valid;
            if (i_valid) begin
                r_s1_v <= w_v;
            end
            if (r_s1_valid) begin
                o_data <= w_o_data;
                o_sat  <= w_sat;
            end
        end
    end

    // Saturation event counter; clear beats a coincident increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_sat_cnt <= '0;
        end else if (i_cnt_clr) begin
            o_sat_cnt <= '0;
        end else if (w_en && r_s1_valid && (|w_sat) && (o_sat_cnt != 16'hFFFF)) begin
            o_sat_cnt <= o_sat_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_stochastic_round_pipe.sv
// Directed self-checking bench for stochastic_round_pipe (default parameters: 4 lanes, 44->20 bits).
module tb_stochastic_round_pipe;
    localparam int unsigned IW = 44;
    localparam int unsigned OW = 20;
    localparam int unsigned LN = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_valid;
    logic              i_ready;
    logic [LN*IW-1:0]  i_data;
    logic [1:0]        i_mode;
    logic              o_valid;
    logic              o_ready;
    logic [LN*OW-1:0]  o_data;
    logic [LN-1:0]     o_sat;
    logic              i_seed_load;
    logic [15:0]       i_seed;
    logic              i_cnt_clr;
    logic [15:0]       o_sat_cnt;

    int checks   = 0;
    int failures = 0;
    logic [LN*OW-1:0] rx_q[$];
    logic [LN*OW-1:0] ref_q[$];

    stochastic_round_pipe dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_ready(i_ready),
        .i_data(i_data), .i_mode(i_mode), .o_valid(o_valid), .o_ready(o_ready),
        .o_data(o_data), .o_sat(o_sat), .i_seed_load(i_seed_load), .i_seed(i_seed),
        .i_cnt_clr(i_cnt_clr), .o_sat_cnt(o_sat_cnt)
    );

    always #5 clk = ~clk;

    // Reference LFSR: Galois, taps 16'hB400, lane seeds SEED ^ k*16'h1D87.
    function automatic logic [15:0] m_seed(input int k);
        logic [15:0] s;
        s = 16'hACE1 ^ 16'(k * 16'h1D87);
        if (s == 16'h0000) s = 16'h0001;
        return s;
    endfunction

    function automatic logic [15:0] m_step(input logic [15:0] s);
        logic [15:0] n;
        n = {1'b0, s[15:1]};
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    function automatic logic [LN*IW-1:0] gen(input int kind, input int i);
        logic [LN*IW-1:0] v;
        logic [IW-1:0]    l;
        v = '0;
        for (int k = 0; k < LN; k++) begin
            case (kind)
                0:       l = 44'h400;
                1:       l = 44'h1000;
                default: l = (44'(i) << 12) | 44'((i * 37 + k * 611) & 'hFFF);
            endcase
            v[k*IW +: IW] = l;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; i_valid = 1'b0; i_cnt_clr = 1'b0; i_seed_load = 1'b0; o_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic run_vec(input logic [LN*IW-1:0] data, input logic [1:0] mode,
                           output logic [LN*OW-1:0] od, output logic [LN-1:0] os, output int lat);
        i_data = data; i_mode = mode; i_valid = 1'b1; o_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        lat = 1;
        while (o_valid !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        od = o_data;
        os = o_sat;
    endtask

    // Streams n vectors, collecting outputs in rx_q; stall randomises o_ready and i_valid gaps.
    task automatic stream(input int n, input int kind, input logic [1:0] mode, input bit stall);
        int sent; int cyc; bit acc; bit fire; bit hold;
        logic [LN*OW-1:0] held;
        sent = 0; cyc = 0;
        rx_q.delete();
        i_mode = mode; i_data = gen(kind, 0); i_valid = (n > 0); o_ready = 1'b1;
        #1;
        while (rx_q.size() < n && cyc < 4*n + 64) begin
            acc  = i_valid && i_ready;
            fire = o_valid && o_ready;
            hold = o_valid && !o_ready;
            held = o_data;
            if (fire) rx_q.push_back(o_data);
            tick();
            if (hold) begin
                checks++;
                if (o_valid !== 1'b1 || o_data !== held) begin
                    failures++;
                    $display("FAIL stall_hold cyc=%0d: got v=%b d=%h want v=1 d=%h", cyc, o_valid, o_data, held);
                end
            end
            if (acc) sent++;
            i_valid = (sent < n) && (!stall || $urandom_range(0, 3) != 0);
            i_data  = gen(kind, sent);
            o_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            cyc++;
        end
        i_valid = 1'b0; o_ready = 1'b1;
        checks++;
        if (rx_q.size() != n) begin
            failures++;
            $display("FAIL stream_count: got %0d want %0d", rx_q.size(), n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_o_valid: got %b want 0", o_valid); end
        checks++; if (i_ready !== 1'b1) begin failures++; $display("FAIL rst_i_ready: got %b want 1", i_ready); end
        checks++; if (o_data !== '0) begin failures++; $display("FAIL rst_o_data: got %h want 0", o_data); end
        checks++; if (o_sat !== '0) begin failures++; $display("FAIL rst_o_sat: got %b want 0", o_sat); end
        checks++; if (o_sat_cnt !== 16'h0) begin failures++; $display("FAIL rst_sat_cnt: got %h want 0", o_sat_cnt); end
    endtask

    task automatic test_truncate();
        logic [LN*OW-1:0] od; logic [LN-1:0] os; int lat; logic [LN*OW-1:0] exp;
        exp = {20'hFFFFF, 20'h00000, 20'hFF000, 20'h01801};
        run_vec({44'hFFFFFFFFFFF, 44'h00000000FFF, 44'hFFFFF000800, 44'h0001801800}, 2'b00, od, os, lat);
        checks++; if (lat != 2) begin failures++; $display("FAIL trunc_latency: got %0d want 2", lat); end
        checks++; if (od !== exp) begin failures++; $display("FAIL trunc_data: got %h want %h", od, exp); end
        checks++; if (os !== 4'b0000) begin failures++; $display("FAIL trunc_sat: got %b want 0000", os); end
    endtask

    task automatic test_rne();
        logic [LN*OW-1:0] od; logic [LN-1:0] os; int lat; logic [LN*OW-1:0] exp;
        exp = {20'h00001, 20'hFF000, 20'h01802, 20'h01800};
        run_vec({44'h00000000C01, 44'hFFFFF000800, 44'h0001801800, 44'h0001800800}, 2'b01, od, os, lat);
        checks++; if (od !== exp || lat != 2) begin failures++; $display("FAIL rne_data: got %h lat %0d want %h lat 2", od, lat, exp); end
        exp = {20'h00000, 20'hFF002, 20'h01802, 20'h01800};
        run_vec({44'h000000007FF, 44'hFFFFF001800, 44'h0001801800, 44'h0001800800}, 2'b11, od, os, lat);
        checks++; if (od !== exp) begin failures++; $display("FAIL rne_mode11: got %h want %h", od, exp); end
    endtask

    task automatic test_saturation();
        logic [LN*OW-1:0] od; logic [LN-1:0] os; int lat; logic [LN*OW-1:0] exp;
        exp = {20'h00000, 20'h00000, 20'h7FFFF, 20'h7FFFF};
        run_vec({44'h0, 44'h0, 44'h0007FFFF000, 44'h7FFFFFFFFFF}, 2'b00, od, os, lat);
        checks++; if (od !== exp || os !== 4'b0001) begin failures++; $display("FAIL sat_pos: got %h/%b want %h/0001", od, os, exp); end
        exp = {20'h00000, 20'h80000, 20'h80000, 20'h80000};
        run_vec({44'h0, 44'hFFF7FFFFFFF, 44'hFFF80000000, 44'h80000000000}, 2'b00, od, os, lat);
        checks++; if (od !== exp || os !== 4'b0101) begin failures++; $display("FAIL sat_neg: got %h/%b want %h/0101", od, os, exp); end
        checks++; if (o_sat_cnt !== 16'd2) begin failures++; $display("FAIL sat_cnt2: got %0d want 2", o_sat_cnt); end
        exp = {20'h00000, 20'h00000, 20'h00000, 20'h7FFFF};
        run_vec({44'h0, 44'h0, 44'h0, 44'h0007FFFFC00}, 2'b01, od, os, lat);
        checks++; if (od !== exp || os !== 4'b0001) begin failures++; $display("FAIL sat_rne_carry: got %h/%b want %h/0001", od, os, exp); end
        checks++; if (o_sat_cnt !== 16'd3) begin failures++; $display("FAIL sat_cnt3: got %0d want 3", o_sat_cnt); end
        // Clear arrives on the same edge that stage 2 captures a saturating vector.
        i_data = {44'h0, 44'h0, 44'h0, 44'h7FFFFFFFFFF}; i_mode = 2'b00; i_valid = 1'b1;
        tick();
        i_valid = 1'b0; i_cnt_clr = 1'b1;
        tick();
        i_cnt_clr = 1'b0;
        checks++; if (o_valid !== 1'b1 || o_sat !== 4'b0001) begin failures++; $display("FAIL clr_vec: got v=%b sat=%b want v=1 sat=0001", o_valid, o_sat); end
        checks++; if (o_sat_cnt !== 16'd0) begin failures++; $display("FAIL clr_wins: got %0d want 0", o_sat_cnt); end
        tick();
    endtask

    task automatic test_stochastic();
        int up; int bad; int exp_up; logic [15:0] s; logic [LN*OW-1:0] e; logic [OW-1:0] lv;
        do_reset();
        stream(4096, 0, 2'b10, 1'b0);
        for (int k = 0; k < LN; k++) begin
            up = 0; bad = 0; exp_up = 0;
            for (int i = 0; i < rx_q.size(); i++) begin
                e = rx_q[i];
                lv = e[k*OW +: OW];
                if (lv == 20'h1) up++;
                else if (lv != 20'h0) bad++;
            end
            s = m_seed(k);
            for (int i = 0; i < 4096; i++) begin
                if (s[11:0] < 12'h400) exp_up++;
                s = m_step(s);
            end
            checks++; if (bad != 0) begin failures++; $display("FAIL stoch_values lane%0d: got %0d bad want 0", k, bad); end
            checks++; if (up != exp_up) begin failures++; $display("FAIL stoch_model lane%0d: got %0d want %0d", k, up, exp_up); end
            checks++; if (up < 896 || up > 1152) begin failures++; $display("FAIL stoch_range lane%0d: got %0d want 1024+-128", k, up); end
        end
        stream(64, 1, 2'b10, 1'b0);
        bad = 0;
        for (int i = 0; i < rx_q.size(); i++) begin
            e = rx_q[i];
            for (int k = 0; k < LN; k++) if (e[k*OW +: OW] != 20'h1) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL stoch_d0: got %0d round-ups want 0", bad); end
    endtask

    task automatic test_seed_repeat();
        int diff;
        i_seed = 16'h1234; i_seed_load = 1'b1;
        tick();
        i_seed_load = 1'b0;
        stream(32, 2, 2'b10, 1'b0);
        ref_q = rx_q;
        i_seed_load = 1'b1;
        tick();
        i_seed_load = 1'b0;
        stream(32, 2, 2'b10, 1'b0);
        diff = 0;
        for (int i = 0; i < 32 && i < rx_q.size() && i < ref_q.size(); i++) if (rx_q[i] !== ref_q[i]) diff++;
        checks++; if (diff != 0 || rx_q.size() != ref_q.size()) begin failures++; $display("FAIL seed_repeat: got %0d differing want 0", diff); end
    endtask

    task automatic test_back_to_back_backpressure();
        logic [LN*OW-1:0] e; logic [OW-1:0] l0;
        do_reset();
        stream(200, 2, 2'b10, 1'b0);
        ref_q = rx_q;
        do_reset();
        stream(200, 2, 2'b10, 1'b1);
        for (int i = 0; i < 200 && i < rx_q.size() && i < ref_q.size(); i++) begin
            e  = rx_q[i];
            l0 = e[OW-1:0];
            checks++;
            if (e !== ref_q[i]) begin failures++; $display("FAIL bp_vs_nostall idx%0d: got %h want %h", i, e, ref_q[i]); end
            checks++;
            if (l0 != 20'(i) && l0 != 20'(i + 1)) begin failures++; $display("FAIL bp_order idx%0d: got %h want %h or %h", i, l0, 20'(i), 20'(i + 1)); end
        end
    endtask

    task automatic test_reset_midstream();
        logic [LN*OW-1:0] od; logic [LN-1:0] os; int lat; logic [LN*OW-1:0] exp;
        do_reset();
        o_ready = 1'b0; i_mode = 2'b00;
        i_data = {44'h0, 44'h0, 44'h0, 44'h7FFFFFFFFFF}; i_valid = 1'b1;
        tick();
        i_data = gen(2, 5);
        tick();
        i_valid = 1'b0;
        checks++; if (o_valid !== 1'b1 || o_sat_cnt !== 16'd1) begin failures++; $display("FAIL mid_pre: got v=%b cnt=%0d want v=1 cnt=1", o_valid, o_sat_cnt); end
        reset = 1'b1;
        tick();
        reset = 1'b0; o_ready = 1'b1;
        checks++; if (o_valid !== 1'b0 || o_sat_cnt !== 16'd0 || o_data !== '0) begin failures++; $display("FAIL mid_reset: got v=%b cnt=%0d d=%h want 0/0/0", o_valid, o_sat_cnt, o_data); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL mid_leftover cyc%0d: got %b want 0", c, o_valid); end
        end
        exp = {20'h00001, 20'h00000, 20'h00001, 20'h00000};
        run_vec({44'h475, 44'h7EF, 44'h167, 44'h0E1}, 2'b10, od, os, lat);
        checks++; if (od !== exp || lat != 2) begin failures++; $display("FAIL mid_fresh_seed: got %h lat %0d want %h lat 2", od, lat, exp); end
    endtask

    initial begin
        reset = 1'b1; i_valid = 1'b0; i_data = '0; i_mode = 2'b00; o_ready = 1'b1;
        i_seed_load = 1'b0; i_seed = 16'h0; i_cnt_clr = 1'b0;
        test_reset();
        test_truncate();
        test_rne();
        test_saturation();
        test_stochastic();
        test_seed_repeat();
        test_back_to_back_backpressure();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
